// File: rtl/swi_cmd_pkg.sv
// Shared types and switch-field positions for the switch-driven memory command front end.
package swi_cmd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } swi_cmd_state_t;

    localparam int OP_BIT   = 1;
    localparam int ADDR_LSB = 2;
    localparam int DATA_LSB = 4;

    localparam int CMD_ADDR_W = 2;
    localparam int CMD_DATA_W = 4;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] data;
    } swi_cmd_t;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus candidate/counter debouncer; strobes stable_evt on the edge
// where a new debounced value is accepted, with evt_value carrying that value.
module sw_debounce #(
    parameter int NBITS_SW        = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NBITS_SW-1:0] sw_in,
    output logic [NBITS_SW-1:0] stable,
    output logic [NBITS_SW-1:0] evt_value,
    output logic                stable_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBITS_SW-1:0] sync1_q, sync1_d;
    logic [NBITS_SW-1:0] sync2_q, sync2_d;
    logic [NBITS_SW-1:0] cand_q, cand_d;
    logic [NBITS_SW-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                evt;

    always_comb begin
        sync1_d  = sw_in;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        evt      = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (cand_q != stable_q) begin
            // Counter stays saturated so a held value fires exactly once.
            stable_d = cand_q;
            evt      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable     = stable_q;
    assign evt_value  = cand_q;
    assign stable_evt = evt;

endmodule

// File: rtl/swi_cmd_debounce.sv
// Debounced switch front end issuing one valid/ready memory command per accepted switch change.
// Optional periodic auto-read when SWI_CMD_REFRESH_EN is defined.
module swi_cmd_debounce
    import swi_cmd_pkg::*;
#(
    parameter int NBITS_SW        = 8,
    parameter int ADDR_W          = 2,
    parameter int DATA_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REFRESH_CYCLES  = 16
) (
    input  logic                clk_2,
    input  logic                reset,
    input  logic [NBITS_SW-1:0] SWI,
    input  logic                cmd_ready,
    output logic                cmd_valid,
    output logic                cmd_write,
    output logic [ADDR_W-1:0]   cmd_addr,
    output logic [DATA_W-1:0]   cmd_data,
    output logic [NBITS_SW-1:0] stable_sw,
    output logic                busy,
    output swi_cmd_state_t      dbg_state,
    output logic [NBITS_SW-1:0] dbg_cmd_sw
);

    if (REFRESH_CYCLES < 2) begin : g_bad_refresh
        $error("REFRESH_CYCLES must be at least 2");
    end

    // Handshake: a command transfers on any edge where cmd_valid && cmd_ready; while cmd_valid
    // is high without cmd_ready the command word is held unchanged.

    logic [NBITS_SW-1:0] evt_value;
    logic                stable_evt;

    sw_debounce #(
        .NBITS_SW       (NBITS_SW),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk_2),
        .reset     (reset),
        .sw_in     (SWI),
        .stable    (stable_sw),
        .evt_value (evt_value),
        .stable_evt(stable_evt)
    );

    swi_cmd_state_t      state_q, state_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [NBITS_SW-1:0] cmd_sw_q, cmd_sw_d;
    logic                pending_q, pending_d;
    logic                handshake;

`ifdef SWI_CMD_REFRESH_EN
    localparam int REF_W = $clog2(REFRESH_CYCLES);
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_CYCLES - 1);
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
`endif

    assign handshake = cmd_valid_q & cmd_ready;

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_sw_d    = cmd_sw_q;
        pending_d   = pending_q;
`ifdef SWI_CMD_REFRESH_EN
        ref_cnt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (stable_evt) begin
                    cmd_sw_d    = evt_value;
                    cmd_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
`ifdef SWI_CMD_REFRESH_EN
                // Periodic re-read keeps the memory's output tracking while the switches select a read.
                else if (!stable_sw[OP_BIT]) begin
                    if (ref_cnt_q == REF_MAX) begin
                        cmd_sw_d    = stable_sw;
                        cmd_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        ref_cnt_d = ref_cnt_q + REF_W'(1);
                    end
                end
`endif
            end
            ISSUE: begin
                if (handshake) begin
                    // A same-edge event wins over the stored pending value: it is newer.
                    if (stable_evt) begin
                        cmd_sw_d = evt_value;
                    end else if (pending_q) begin
                        cmd_sw_d = stable_sw;
                    end else begin
                        cmd_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                    pending_d = 1'b0;
                end else if (stable_evt) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_valid_d = 1'b0;
                pending_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_sw_q    <= '0;
            pending_q   <= 1'b0;
`ifdef SWI_CMD_REFRESH_EN
            ref_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_sw_q    <= cmd_sw_d;
            pending_q   <= pending_d;
`ifdef SWI_CMD_REFRESH_EN
            ref_cnt_q   <= ref_cnt_d;
`endif
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_write  = cmd_sw_q[OP_BIT];
    assign cmd_addr   = cmd_sw_q[ADDR_LSB +: ADDR_W];
    assign cmd_data   = cmd_sw_q[DATA_LSB +: DATA_W];
    assign busy       = (state_q == ISSUE) | pending_q;
    assign dbg_state  = state_q;
    assign dbg_cmd_sw = cmd_sw_q;

endmodule

// File: tb/tb_swi_cmd_debounce.sv
// Directed and randomized bench for swi_cmd_debounce against a window-based reference model.
module tb_swi_cmd_debounce;

    localparam int D = 4;
    localparam int R = 16;

    logic       clk_2 = 1'b0;
    logic       rst;
    logic [7:0] swi;
    logic       rdy;
    logic       cmd_valid;
    logic       cmd_write;
    logic [1:0] cmd_addr;
    logic [3:0] cmd_data;
    logic [7:0] stable_sw;
    logic       busy;
    swi_cmd_pkg::swi_cmd_state_t dbg_state;
    logic [7:0] dbg_cmd_sw;

    swi_cmd_debounce #(
        .NBITS_SW       (8),
        .ADDR_W         (2),
        .DATA_W         (4),
        .DEBOUNCE_CYCLES(D),
        .REFRESH_CYCLES (R)
    ) dut (
        .clk_2     (clk_2),
        .reset     (rst),
        .SWI       (swi),
        .cmd_ready (rdy),
        .cmd_valid (cmd_valid),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .stable_sw (stable_sw),
        .busy      (busy),
        .dbg_state (dbg_state),
        .dbg_cmd_sw(dbg_cmd_sw)
    );

    always #5 clk_2 = ~clk_2;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: SWI values seen at each edge since reset; a value is accepted once it
    // occupies the whole D+1 wide window ending two edges back (the synchroniser delay).
    logic [7:0] raw_q[$];
    logic [7:0] m_stable;
    logic       m_valid;
    logic [7:0] m_sw;
    logic       m_pending;
    int         m_ref;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic       evt;
        logic [7:0] v;
        if (rst) begin
            raw_q     = {8'h00, 8'h00, 8'h00};
            m_stable  = 8'h00;
            m_valid   = 1'b0;
            m_sw      = 8'h00;
            m_pending = 1'b0;
            m_ref     = 0;
            return;
        end
        raw_q.push_back(swi);
        while (raw_q.size() > D + 3) void'(raw_q.pop_front());
        evt = 1'b0;
        v   = raw_q[raw_q.size() - 3];
        if (raw_q.size() == D + 3) begin
            evt = (v != m_stable);
            for (int i = 0; i <= D; i++) if (raw_q[i] != v) evt = 1'b0;
        end
        if (!m_valid) begin
            if (evt) begin
                m_sw    = v;
                m_valid = 1'b1;
                m_ref   = 0;
            end
`ifdef SWI_CMD_REFRESH_EN
            else if (!m_stable[1]) begin
                if (m_ref == R - 1) begin
                    m_sw    = m_stable;
                    m_valid = 1'b1;
                    m_ref   = 0;
                end else begin
                    m_ref++;
                end
            end else begin
                m_ref = 0;
            end
`endif
        end else begin
            m_ref = 0;
            if (rdy) begin
                if (evt) m_sw = v;
                else if (m_pending) m_sw = m_stable;
                else m_valid = 1'b0;
                m_pending = 1'b0;
            end else if (evt) begin
                m_pending = 1'b1;
            end
        end
        if (evt) m_stable = v;
    endtask

    task automatic check_all();
        chk("valid", cmd_valid, m_valid);
        chk("stable_sw", stable_sw, m_stable);
        chk("busy", busy, m_valid | m_pending);
        chk("state", dbg_state, m_valid);
        if (m_valid) begin
            chk("write", cmd_write, m_sw[1]);
            chk("addr", cmd_addr, m_sw[3:2]);
            if (m_sw[1]) chk("data", cmd_data, m_sw[7:4]);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int rises;
        logic prev_v;
        logic [7:0] pick;
        int hold;

        rst = 1'b1;
        swi = 8'h00;
        rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Quiet switches after reset
        for (int i = 0; i < 50; i++) begin
            tick();
`ifndef SWI_CMD_REFRESH_EN
            chk("t1_quiet", cmd_valid, 1'b0);
`endif
        end
        chk("t1_stable", stable_sw, 8'h00);
        chk("t1_busy", busy, 1'b0);

        // Single write command, latency to edge D+2
        rdy = 1'b1;
        swi = 8'hA6;
        for (int i = 0; i < D + 2; i++) tick();
        chk("t2_early", cmd_valid, 1'b0);
        tick();
        chk("t2_stable", stable_sw, 8'hA6);
        chk("t2_valid", cmd_valid, 1'b1);
        chk("t2_write", cmd_write, 1'b1);
        chk("t2_addr", cmd_addr, 2'b01);
        chk("t2_data", cmd_data, 4'hA);
        tick();
        chk("t2_drop", cmd_valid, 1'b0);

        // Short glitch never becomes stable
        swi = 8'h00;
        for (int i = 0; i < 12; i++) tick();
        swi = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        swi = 8'h00;
        for (int i = 0; i < 15; i++) begin
            tick();
`ifndef SWI_CMD_REFRESH_EN
            chk("t3_quiet", cmd_valid, 1'b0);
`endif
        end
        chk("t3_stable", stable_sw, 8'h00);

        // Events while stalled coalesce into a pending back-to-back command
        rdy = 1'b0;
        swi = 8'hA6;
        for (int i = 0; i < 8; i++) tick();
        swi = 8'h58;
        for (int i = 0; i < 8; i++) tick();
`ifndef SWI_CMD_REFRESH_EN
        chk("t4_hold_write", cmd_write, 1'b1);
        chk("t4_hold_addr", cmd_addr, 2'b01);
        chk("t4_hold_data", cmd_data, 4'hA);
`endif
        chk("t4_stable", stable_sw, 8'h58);
        chk("t4_busy", busy, 1'b1);
        rdy = 1'b1;
        tick();
        chk("t4_b2b_valid", cmd_valid, 1'b1);
        chk("t4_b2b_write", cmd_write, 1'b0);
        chk("t4_b2b_addr", cmd_addr, 2'b10);
        chk("t4_b2b_data", cmd_data, 4'h5);
        tick();
`ifndef SWI_CMD_REFRESH_EN
        chk("t4_done", cmd_valid, 1'b0);
`endif

        // Reset while a command is stalled
        rdy = 1'b0;
        swi = 8'hA6;
        for (int i = 0; i < 8; i++) tick();
        chk("t5_pre_valid", cmd_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("t5_valid", cmd_valid, 1'b0);
        chk("t5_stable", stable_sw, 8'h00);
        chk("t5_busy", busy, 1'b0);

        // Read selection: one command, or periodic reads with refresh
        rst = 1'b0;
        swi = 8'h04;
        rdy = 1'b1;
        rises = 0;
        prev_v = cmd_valid;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (cmd_valid && !prev_v) rises++;
            prev_v = cmd_valid;
        end
`ifdef SWI_CMD_REFRESH_EN
        chk("t6_rises", rises, 4);
`else
        chk("t6_rises", rises, 1);
`endif

        // Randomized switch activity, back-pressure and occasional resets
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 5))
                0: pick = 8'h00;
                1: pick = 8'hA6;
                2: pick = 8'h58;
                3: pick = 8'h04;
                4: pick = 8'hFF;
                default: pick = 8'($urandom_range(0, 255));
            endcase
            swi  = pick;
            hold = $urandom_range(1, 10);
            for (int k = 0; k < hold; k++) begin
                rdy = ($urandom_range(0, 3) != 0);
                rst = ($urandom_range(0, 199) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
